data_mem_io: RTL and testbench

// - Responder for the CPU data port: services data_addr / data_out / mem_write_en, returns data_in.
// - Holds data RAM plus a memory-mapped I/O page:
//   - LED register
//   - TX FIFO toward a serial transmitter
//   - status register
//   - free-running cycle counter
// - Reads are combinational so the CPU samples data_in in the same CPU step.
// - Writes commit once per CPU step, never once per clk.

---
 rtl/data_mem_io_if.sv | 27 ++
 rtl/data_mem_io.sv | 111 +++++++++++
 tb/tb_data_mem_io.sv | 242 ++++++++++++++++++++++++
 3 files changed

// File: rtl/data_mem_io_if.sv
// CPU data-port bus plus the TX byte stream toward the serial transmitter.
// master = CPU/top-level side, slave = data_mem_io.
interface data_mem_io_if #(
  parameter int WORD_WIDTH = 16
);
  logic                  cpu_step;
  logic [WORD_WIDTH-1:0] addr;
  logic [WORD_WIDTH-1:0] wdata;
  logic                  write_en;
  logic [WORD_WIDTH-1:0] rdata;
  logic [WORD_WIDTH-1:0] leds;
  // TX stream: a byte transfers on a clk where tx_valid && tx_ready; tx_data is
  // held stable while tx_valid && !tx_ready, and tx_valid never depends on tx_ready.
  logic [7:0]            tx_data;
  logic                  tx_valid;
  logic                  tx_ready;

  modport master (
    output cpu_step, addr, wdata, write_en, tx_ready,
    input  rdata, leds, tx_data, tx_valid
  );

  modport slave (
    input  cpu_step, addr, wdata, write_en, tx_ready,
    output rdata, leds, tx_data, tx_valid
  );
endinterface

// File: rtl/data_mem_io.sv
// Data RAM plus memory-mapped I/O page (LEDs, TX FIFO, status, cycle counter).
// Reads are combinational; writes commit only on a cpu_step clk.
module data_mem_io #(
  parameter int                    WORD_WIDTH = 16,
  parameter int                    RAM_DEPTH  = 256,
  parameter int                    FIFO_DEPTH = 8,
  parameter logic [WORD_WIDTH-1:0] IO_BASE    = 16'hFF00
) (
  input logic          clk,
  input logic          rst,
  data_mem_io_if.slave bus
);
  localparam int AW = $clog2(RAM_DEPTH);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [WORD_WIDTH-1:0] ADDR_LEDS   = IO_BASE;
  localparam logic [WORD_WIDTH-1:0] ADDR_TX     = IO_BASE + WORD_WIDTH'(1);
  localparam logic [WORD_WIDTH-1:0] ADDR_STATUS = IO_BASE + WORD_WIDTH'(2);
  localparam logic [WORD_WIDTH-1:0] ADDR_CYCLES = IO_BASE + WORD_WIDTH'(3);

  logic [WORD_WIDTH-1:0] ram_q [RAM_DEPTH];
  logic [7:0]            fifo_q [FIFO_DEPTH];
  logic [PW-1:0]         rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]         count_q, count_d;
  logic [WORD_WIDTH-1:0] leds_q, leds_d, cycles_q, cycles_d;
  logic                  overflow_q, overflow_d;

  logic                  commit, is_ram, ram_we;
  logic                  sel_leds, sel_tx, sel_status, sel_cycles;
  logic                  fifo_empty, fifo_full, pop, push, push_ok;
  logic [AW-1:0]         ram_idx;
  logic [3:0]            count_disp;
  logic [WORD_WIDTH-1:0] rdata;

  always_comb begin
    commit     = bus.cpu_step & bus.write_en;
    is_ram     = 32'(bus.addr) < RAM_DEPTH;
    ram_idx    = bus.addr[AW-1:0];
    sel_leds   = !is_ram && (bus.addr == ADDR_LEDS);
    sel_tx     = !is_ram && (bus.addr == ADDR_TX);
    sel_status = !is_ram && (bus.addr == ADDR_STATUS);
    sel_cycles = !is_ram && (bus.addr == ADDR_CYCLES);
    fifo_empty = (count_q == '0);
    fifo_full  = (count_q == CW'(FIFO_DEPTH));
    pop        = !fifo_empty && bus.tx_ready;
    push       = commit && sel_tx;
    // A full FIFO still takes a push when the head leaves in the same clk.
    push_ok    = push && (!fifo_full || pop);
    // Reset outranks a coincident RAM write even though RAM itself is not reset.
    ram_we     = commit && is_ram && rst;
    count_disp = (32'(count_q) > 32'd15) ? 4'hF : 4'(count_q);
  end

  always_comb begin
    rdata = '0;
    if (is_ram) begin
      rdata = ram_q[ram_idx];
    end else if (sel_leds) begin
      rdata = leds_q;
    end else if (sel_status) begin
      rdata = WORD_WIDTH'({count_disp, overflow_q, fifo_empty, fifo_full, 1'b0});
    end else if (sel_cycles) begin
      rdata = cycles_q;
    end
  end

  always_comb begin
    leds_d     = leds_q;
    overflow_d = overflow_q;
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    count_d    = count_q + CW'(push_ok) - CW'(pop);
    cycles_d   = cycles_q + WORD_WIDTH'(1);
    if (commit && sel_leds)   leds_d     = bus.wdata;
    if (commit && sel_status) overflow_d = 1'b0;
    if (push && !push_ok)     overflow_d = 1'b1;
    if (pop)                  rd_ptr_d   = rd_ptr_q + PW'(1);
    if (push_ok)              wr_ptr_d   = wr_ptr_q + PW'(1);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      leds_q     <= '0;
      overflow_q <= 1'b0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
      cycles_q   <= '0;
    end else begin
      leds_q     <= leds_d;
      overflow_q <= overflow_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
      cycles_q   <= cycles_d;
    end
  end

  always_ff @(posedge clk) begin
    if (ram_we) ram_q[ram_idx] <= bus.wdata;
  end

  always_ff @(posedge clk) begin
    if (push_ok && rst) fifo_q[wr_ptr_q] <= bus.wdata[7:0];
  end

  assign bus.rdata    = rdata;
  assign bus.leds     = leds_q;
  assign bus.tx_valid = !fifo_empty;
  assign bus.tx_data  = fifo_empty ? 8'h00 : fifo_q[rd_ptr_q];
endmodule

// File: tb/tb_data_mem_io.sv
// Bench for data_mem_io: directed scenarios with literal expectations, then random
// traffic checked every cycle against a queue/array model of the memory map.
module tb_data_mem_io;
  localparam int W  = 16;
  localparam int RD = 256;
  localparam int FD = 8;
  localparam logic [W-1:0] A_LEDS = 16'hFF00;
  localparam logic [W-1:0] A_TX   = 16'hFF01;
  localparam logic [W-1:0] A_STAT = 16'hFF02;
  localparam logic [W-1:0] A_CYC  = 16'hFF03;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  data_mem_io_if #(.WORD_WIDTH(W)) bus();

  data_mem_io #(
    .WORD_WIDTH(W), .RAM_DEPTH(RD), .FIFO_DEPTH(FD), .IO_BASE(16'hFF00)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int total = 0;
  int bad   = 0;

  // ---------------- behavioural model ----------------
  logic [W-1:0] m_ram [RD];
  bit           m_known [RD];
  logic [W-1:0] m_leds;
  logic [W-1:0] m_cycles;
  bit           m_ovf;
  bit           m_live = 1'b0;
  logic [W-1:0] exp_q[$];   // bytes queued toward the transmitter, head first

  always @(posedge clk) begin : model
    bit m_pop, m_full, m_commit;
    if (!rst) begin
      m_leds   = '0;
      m_ovf    = 1'b0;
      m_cycles = '0;
      exp_q.delete();
      m_live   = 1'b1;
    end else if (m_live) begin
      m_pop    = (exp_q.size() != 0) && bus.tx_ready;
      m_full   = (exp_q.size() == FD);
      m_commit = bus.cpu_step && bus.write_en;
      m_cycles = m_cycles + 16'd1;
      if (m_pop) void'(exp_q.pop_front());
      if (m_commit) begin
        if (bus.addr < RD) begin
          m_ram[bus.addr[7:0]]   = bus.wdata;
          m_known[bus.addr[7:0]] = 1'b1;
        end else begin
          case (bus.addr)
            A_LEDS: m_leds = bus.wdata;
            A_TX: begin
              if (!m_full || m_pop) exp_q.push_back({8'h00, bus.wdata[7:0]});
              else m_ovf = 1'b1;
            end
            A_STAT: m_ovf = 1'b0;
            default: ;
          endcase
        end
      end
    end
  end

  function automatic logic [W-1:0] exp_rd(input logic [W-1:0] a);
    int         n = exp_q.size();
    logic [3:0] c = (n > 15) ? 4'hF : 4'(n);
    if (a < RD) return m_ram[a[7:0]];
    case (a)
      A_LEDS: return m_leds;
      A_STAT: return {8'h00, c, m_ovf, n == 0, n == FD, 1'b0};
      A_CYC:  return m_cycles;
      default: return '0;
    endcase
  endfunction

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- scoreboard compare ----------------
  always @(negedge clk) begin
    if (m_live) begin
      chk("leds", bus.leds, m_leds);
      chk("tx_valid", W'(bus.tx_valid), W'(exp_q.size() != 0));
      chk("tx_data", W'(bus.tx_data), (exp_q.size() != 0) ? exp_q[0] : '0);
      if (bus.addr >= RD || m_known[bus.addr[7:0]])
        chk("rdata", bus.rdata, exp_rd(bus.addr));
    end
  end

  // ---------------- driver tasks ----------------
  task automatic drive(input bit step, input bit we, input logic [W-1:0] a,
                       input logic [W-1:0] d, input bit rdy);
    bus.cpu_step = step;
    bus.write_en = we;
    bus.addr     = a;
    bus.wdata    = d;
    bus.tx_ready = rdy;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cyc(input bit step, input bit we, input logic [W-1:0] a,
                     input logic [W-1:0] d, input bit rdy);
    drive(step, we, a, d, rdy);
    tick();
  endtask

  task automatic rand_cyc(input bit allow_rst, input int rdy_bias);
    logic [W-1:0] a;
    int k = $urandom_range(0, 9);
    if (k < 3)      a = W'($urandom_range(0, 15));
    else if (k < 5) a = W'($urandom_range(0, RD - 1));
    else if (k < 8) a = A_LEDS + W'($urandom_range(0, 5));
    else            a = W'($urandom);
    rst = !(allow_rst && ($urandom_range(0, 299) == 0));
    drive($urandom_range(0, 2) == 0, $urandom_range(0, 1) == 1, a, W'($urandom),
          $urandom_range(0, 9) < rdy_bias);
    tick();
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    logic [W-1:0] drain_exp [8];
    int guard;
    drain_exp = '{16'h51, 16'h52, 16'h53, 16'h54, 16'h55, 16'h56, 16'h57, 16'h59};

    rst = 1'b0;
    drive(0, 0, A_CYC, 16'h0, 0);
    tick();
    tick();
    chk("rst_leds", bus.leds, 16'h0000);
    chk("rst_tx_valid", W'(bus.tx_valid), 16'h0000);
    chk("rst_tx_data", W'(bus.tx_data), 16'h0000);
    chk("rst_cycles", bus.rdata, 16'h0000);
    rst = 1'b1;
    drive(0, 0, A_STAT, 16'h0, 0);
    #1 chk("rst_status", bus.rdata, 16'h0004);

    // one commit despite write_en held for many clks
    cyc(1, 1, 16'd5, 16'h0000, 0);
    drive(0, 1, 16'd5, 16'hBEEF, 0);
    repeat (30) tick();
    chk("ram5_no_step", bus.rdata, 16'h0000);
    cyc(1, 1, 16'd5, 16'hBEEF, 0);
    drive(0, 1, 16'd5, 16'h1111, 0);
    repeat (33) tick();
    drive(0, 0, 16'd5, 16'h0, 0);
    #1 chk("ram5_beef", bus.rdata, 16'hBEEF);

    // three bytes queued, then drained in order
    cyc(1, 1, A_TX, 16'h0041, 0);
    cyc(1, 1, A_TX, 16'h0042, 0);
    cyc(1, 1, A_TX, 16'h0043, 0);
    drive(0, 0, A_STAT, 16'h0, 0);
    #1 chk("status_cnt3", bus.rdata, 16'h0030);
    chk("head_41", W'(bus.tx_data), 16'h0041);
    cyc(0, 0, A_STAT, 16'h0, 1);
    chk("head_42", W'(bus.tx_data), 16'h0042);
    cyc(0, 0, A_STAT, 16'h0, 1);
    chk("head_43", W'(bus.tx_data), 16'h0043);
    cyc(0, 0, A_STAT, 16'h0, 1);
    chk("drained_valid", W'(bus.tx_valid), 16'h0000);
    chk("drained_status", bus.rdata, 16'h0004);

    // overflow: ninth byte dropped, status write clears the sticky flag
    for (int i = 0; i < 9; i++) cyc(1, 1, A_TX, W'(16'h50 + i), 0);
    drive(0, 0, A_STAT, 16'h0, 0);
    #1 chk("status_full_ovf", bus.rdata, 16'h008A);
    chk("head_50", W'(bus.tx_data), 16'h0050);
    cyc(1, 1, A_STAT, 16'h0, 0);
    chk("status_ovf_clr", bus.rdata, 16'h0082);

    // full FIFO: push and pop in the same clk
    cyc(1, 1, A_TX, 16'h0059, 1);
    drive(0, 0, A_STAT, 16'h0, 0);
    #1 chk("status_full_pushpop", bus.rdata, 16'h0082);
    for (int i = 0; i < 8; i++) begin
      chk("drain_order", W'(bus.tx_data), drain_exp[i]);
      cyc(0, 0, A_STAT, 16'h0, 1);
    end
    chk("drain_done_valid", W'(bus.tx_valid), 16'h0000);

    // reset in the middle of a drain
    cyc(1, 1, A_TX, 16'h0061, 0);
    cyc(1, 1, A_TX, 16'h0062, 0);
    cyc(1, 1, A_TX, 16'h0063, 0);
    cyc(1, 1, A_LEDS, 16'h00A5, 0);
    chk("leds_a5", bus.leds, 16'h00A5);
    cyc(0, 0, A_STAT, 16'h0, 1);
    rst = 1'b0;
    cyc(1, 1, 16'd5, 16'h2222, 1);
    chk("midrst_tx_valid", W'(bus.tx_valid), 16'h0000);
    chk("midrst_leds", bus.leds, 16'h0000);
    rst = 1'b1;
    drive(0, 0, A_CYC, 16'h0, 0);
    #1 chk("midrst_cycles", bus.rdata, 16'h0000);
    drive(0, 0, 16'd5, 16'h0, 0);
    #1 chk("midrst_ram5", bus.rdata, 16'hBEEF);

    // unmapped address
    drive(0, 0, 16'h1234, 16'h0, 0);
    #1 chk("unmapped_rd", bus.rdata, 16'h0000);
    cyc(1, 1, 16'h1234, 16'hFFFF, 0);
    chk("unmapped_wr_leds", bus.leds, 16'h0000);
    drive(0, 0, A_STAT, 16'h0, 0);
    #1 chk("unmapped_wr_status", bus.rdata, 16'h0004);

    // random traffic with occasional resets, then run on to the counter wrap
    for (int n = 0; n < 1500; n++) rand_cyc(1'b1, (n < 750) ? 2 : 6);
    rst = 1'b1;
    guard = 0;
    while (m_cycles != 16'hFFFE && guard < 70000) begin
      rand_cyc(1'b0, 5);
      guard++;
    end
    drive(0, 0, A_CYC, 16'h0, 0);
    #1 chk("cycles_fffe", bus.rdata, 16'hFFFE);
    tick();
    chk("cycles_ffff", bus.rdata, 16'hFFFF);
    tick();
    chk("cycles_wrap", bus.rdata, 16'h0000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
